// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and widths for the fifo write arbiter.
// No ports; imported by rr_picker and fifo_write_arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  localparam int OWNER_W = 3;
  localparam int BEAT_W = 8;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first request at or after a pointer.
// Ports: i_req (request vector), i_rr_ptr (search start index),
//        o_winner (index of first set request from i_rr_ptr, wrapping), o_valid (any request).
module rr_picker import fifo_arb_pkg::*; #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   i_req,
  input  logic [OWNER_W-1:0] i_rr_ptr,
  output logic [OWNER_W-1:0] o_winner,
  output logic               o_valid
);
  logic [N_REQ-1:0]   w_rot;
  logic [OWNER_W-1:0] w_idx;
  logic [OWNER_W:0]   w_sum;
  // Rotate so that i_rr_ptr lands on bit 0; the shift by N_REQ at pointer 0 yields zero.
  assign w_rot = (i_req >> i_rr_ptr) | (i_req << (N_REQ - int'(i_rr_ptr)));
  always_comb begin
    w_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) if (w_rot[i]) w_idx = OWNER_W'(i);
  end
  // Rotate back: add the pointer and wrap modulo N_REQ.
  assign w_sum    = {1'b0, w_idx} + {1'b0, i_rr_ptr};
  assign o_winner = (w_sum >= (OWNER_W + 1)'(N_REQ)) ? OWNER_W'(w_sum - (OWNER_W + 1)'(N_REQ)) : w_sum[OWNER_W-1:0];
  assign o_valid  = |i_req;
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-granular sharing of one fifo write port among N_REQ producers.
// Ports: clk, reset (sync, active-high); req/req_data/req_last from producers; grant per-producer
//        beat strobe; fifo_full/fifo_almost_full from the fifo; fifo_wr_en/fifo_wr_data to the fifo;
//        busy (burst in progress), owner (current owner index), abort (registered pulse when the
//        owner drops req mid-burst).
module fifo_write_arbiter import fifo_arb_pkg::*; #(
  parameter int N_REQ             = 4,
  parameter int MAX_BURST         = 8,
  parameter int THROTTLE_ON_AFULL = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     grant,
  input  logic                 fifo_full,
  input  logic                 fifo_almost_full,
  output logic                 fifo_wr_en,
  output logic [7:0]           fifo_wr_data,
  output logic                 busy,
  output logic [OWNER_W-1:0]   owner,
  output logic                 abort
);
  state_t             r_state, w_state_nx;
  logic [OWNER_W-1:0] r_owner, w_owner_nx, r_rr_ptr, w_rr_ptr_nx, w_winner;
  logic [BEAT_W-1:0]  r_beat_cnt, w_beat_cnt_nx, w_beat_inc;
  logic               r_abort, w_abort_nx;
  logic               w_valid, w_eligible, w_own_req, w_own_last, w_accept, w_end;
  logic [7:0]         w_req_x, w_last_x;
  logic [63:0]        w_data_x;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  // Widen to the full 3-bit owner range so owner-indexed selects need no bounds logic.
  assign w_req_x    = 8'(req);
  assign w_last_x   = 8'(req_last);
  assign w_data_x   = 64'(req_data);
  assign w_own_req  = w_req_x[r_owner];
  assign w_own_last = w_last_x[r_owner];

  assign w_eligible = w_valid && !fifo_full && !((THROTTLE_ON_AFULL != 0) && fifo_almost_full);
  // Reset gates the write so nothing reaches the fifo in a reset cycle.
  assign w_accept   = (r_state == BURST) && w_own_req && !fifo_full && !reset;
  assign w_beat_inc = r_beat_cnt + 1'b1;
  // A single end event covers last beat, burst cap and owner dropping req.
  assign w_end      = (r_state == BURST) &&
                      (!w_own_req || (w_accept && (w_own_last || w_beat_inc == BEAT_W'(MAX_BURST))));

  assign fifo_wr_en   = w_accept;
  assign grant        = w_accept ? (N_REQ'(1) << r_owner) : '0;
  assign fifo_wr_data = w_data_x[{r_owner, 3'b000} +: 8];
  assign busy         = r_state == BURST;
  assign owner        = r_owner;
  assign abort        = r_abort;

  always_comb begin
    w_state_nx    = r_state;
    w_owner_nx    = r_owner;
    w_rr_ptr_nx   = r_rr_ptr;
    w_beat_cnt_nx = r_beat_cnt;
    w_abort_nx    = 1'b0;
    if (r_state == IDLE) begin
      if (w_eligible) begin
        w_state_nx    = BURST;
        w_owner_nx    = w_winner;
        w_beat_cnt_nx = '0;
      end
    end else begin
      if (w_accept) w_beat_cnt_nx = w_beat_inc;
      if (w_end) begin
        w_state_nx  = IDLE;
        w_rr_ptr_nx = (r_owner == OWNER_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
        w_abort_nx  = !w_own_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_owner    <= w_owner_nx;
      r_rr_ptr   <= w_rr_ptr_nx;
      r_beat_cnt <= w_beat_cnt_nx;
      r_abort    <= w_abort_nx;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: scoreboard bench with a transaction-level reference model of the arbiter.
module tb_fifo_write_arbiter;
  localparam int N = 4;
  localparam int MAXB = 8;
  typedef struct {logic [7:0] d; bit l;} beat_t;
  typedef struct {bit chk_st; bit busy; int owner; bit abort; bit wr; logic [N-1:0] grant;} cyc_t;
  typedef struct {int src; logic [7:0] d;} wr_t;

  logic clk = 0, reset = 1;
  logic [N-1:0] req = '0, req_last = '0, grant;
  logic [8*N-1:0] req_data = '0;
  logic fifo_full = 0, fifo_almost_full = 0, fifo_wr_en, busy, abort;
  logic [7:0] fifo_wr_data;
  logic [2:0] owner;

  beat_t pq[N][$];
  logic [7:0] exp_s[N][$];
  cyc_t cq[$];
  wr_t dq[$];
  wr_t wlog[$];
  int checks = 0, failures = 0, abort_cnt = 0;
  bit hold[N];
  bit rst_drv = 1, afull_drv = 0, rnd = 0, drop3 = 0, rst2 = 0;
  int stall_left = 0, rst_idx = -1;
  int m_owner = -1, m_ptr = 0, m_beats = 0;
  bit m_abort = 0, m_known = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.N_REQ(N), .MAX_BURST(MAXB), .THROTTLE_ON_AFULL(1)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
    .grant(grant), .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .busy(busy), .owner(owner), .abort(abort)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] b);
    checks++;
    if (a !== b) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, a, b, $time);
    end
  endtask

  task automatic push_beat(input int p, input logic [7:0] d, input bit l);
    beat_t b;
    b.d = d;
    b.l = l;
    pq[p].push_back(b);
  endtask

  function automatic bit quiet();
    for (int i = 0; i < N; i++) if (pq[i].size() > 0 && !hold[i]) return 0;
    return 1;
  endfunction

  // Reference model: one call per clock cycle, given this cycle's inputs.
  task automatic model_step();
    cyc_t e;
    e.chk_st = m_known;
    e.busy = m_owner >= 0;
    e.owner = m_owner;
    e.abort = m_abort;
    e.wr = 0;
    e.grant = '0;
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_beats = 0; m_abort = 0; m_known = 1;
    end else if (m_owner < 0) begin
      m_abort = 0;
      if (req != 0 && !fifo_full && !fifo_almost_full)
        for (int k = 0; k < N; k++)
          if (m_owner < 0 && req[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            m_beats = 0;
          end
    end else begin
      m_abort = 0;
      if (!req[m_owner]) begin
        m_abort = 1;
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end else if (!fifo_full) begin
        beat_t b;
        wr_t w;
        b = pq[m_owner].pop_front();
        e.wr = 1;
        e.grant[m_owner] = 1'b1;
        w.src = m_owner;
        w.d = b.d;
        dq.push_back(w);
        m_beats++;
        if (b.l || m_beats == MAXB) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end
    cq.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (rnd) begin
      fifo_full = $urandom_range(0, 4) == 0;
      fifo_almost_full = $urandom_range(0, 3) == 0;
    end else begin
      fifo_full = stall_left > 0 && m_owner == 1 && m_beats == 2;
      fifo_almost_full = afull_drv;
      if (fifo_full) stall_left--;
    end
    if (drop3 && m_owner == 3 && m_beats == 2) hold[3] = 1;
    reset = rst_drv;
    if (rst2 && m_owner == 2 && m_beats == 2) begin
      reset = 1;
      rst2 = 0;
      rst_idx = wlog.size();
      push_beat(0, 8'hC0, 1'b1);
    end
    for (int i = 0; i < N; i++) begin
      req[i] = pq[i].size() > 0 && !hold[i];
      req_last[i] = pq[i].size() > 0 ? pq[i][0].l : 1'b0;
      req_data[8*i +: 8] = pq[i].size() > 0 ? pq[i][0].d : 8'h5A;
    end
    model_step();
  endtask

  task automatic run_until_idle(input string n, input int limit);
    int c;
    c = 0;
    while (c < limit && !(m_owner < 0 && quiet())) begin
      cycle();
      c++;
    end
    checks++;
    if (c >= limit) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d cycles required<%0d", n, c, limit);
    end
    cycle();
    cycle();
  endtask

  always @(negedge clk) begin
    cyc_t e;
    wr_t x;
    wr_t w;
    if (abort === 1'b1) abort_cnt++;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      chk("wr_en", 32'(fifo_wr_en), 32'(e.wr));
      chk("grant", 32'(grant), 32'(e.grant));
      if (e.chk_st) begin
        chk("busy", 32'(busy), 32'(e.busy));
        chk("abort", 32'(abort), 32'(e.abort));
        if (e.busy) chk("owner", 32'(owner), e.owner);
      end
    end
    if (fifo_wr_en === 1'b1) begin
      chk("no_overflow", 32'(fifo_full), 0);
      w.src = int'(owner);
      w.d = fifo_wr_data;
      wlog.push_back(w);
      if (dq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_write actual=%0h required=none", fifo_wr_data);
      end else begin
        x = dq.pop_front();
        chk("wr_src", 32'(owner), x.src);
        chk("wr_data", 32'(fifo_wr_data), 32'(x.d));
      end
    end
  end

  initial begin
    int base, a0, n2, total, len, p, j;
    cycle();
    cycle();
    rst_drv = 0;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_owner", 32'(owner), 0);
    chk("reset_abort", 32'(abort), 0);

    // contention: all four request single-beat bursts
    base = wlog.size();
    for (int i = 0; i < N; i++) begin
      push_beat(i, 8'(16 * i + 1), 1'b1);
      push_beat(i, 8'(16 * i + 2), 1'b1);
    end
    run_until_idle("contention", 100);
    for (int k = 0; k < 5; k++) chk("rr_order", wlog[base + k].src, k % N);

    // burst cap: 20 beats from producer 2 without last
    base = wlog.size();
    a0 = abort_cnt;
    for (int k = 0; k < 20; k++) push_beat(2, 8'(8'h40 + k), 1'b0);
    run_until_idle("burst_cap", 200);
    n2 = 0;
    for (int k = base; k < wlog.size(); k++) if (wlog[k].src == 2) n2++;
    chk("cap_writes", wlog.size() - base, 20);
    chk("cap_all_p2", n2, 20);
    chk("cap_abort", abort_cnt - a0, 1);

    // full stall at beat 3 of a 5-beat burst
    base = wlog.size();
    stall_left = 3;
    for (int k = 0; k < 5; k++) push_beat(1, 8'(8'h80 + k), k == 4);
    run_until_idle("stall", 100);
    chk("stall_writes", wlog.size() - base, 5);
    for (int k = 0; k < 5; k++) chk("stall_order", 32'(wlog[base + k].d), 32'h80 + k);

    // throttle on almost_full
    afull_drv = 1;
    for (int k = 0; k < 3; k++) push_beat(2, 8'(8'h90 + k), k == 2);
    repeat (4) cycle();
    chk("throttle_idle", 32'(busy), 0);
    afull_drv = 0;
    cycle();
    cycle();
    chk("throttle_go", 32'(busy), 1);
    run_until_idle("throttle", 100);

    // abort after two beats, then reset mid-burst
    a0 = abort_cnt;
    drop3 = 1;
    for (int k = 0; k < 4; k++) push_beat(3, 8'(8'hD0 + k), 1'b0);
    run_until_idle("abort", 100);
    drop3 = 0;
    chk("abort_pulse", abort_cnt - a0, 1);
    pq[3].delete();
    hold[3] = 0;
    base = wlog.size();
    push_beat(0, 8'hE0, 1'b0);
    push_beat(0, 8'hE1, 1'b1);
    for (int k = 0; k < 6; k++) push_beat(2, 8'(8'hF0 + k), k == 5);
    rst2 = 1;
    run_until_idle("reset_mid", 200);
    chk("after_abort_src", wlog[base].src, 0);
    chk("post_reset_src", wlog[rst_idx].src, 0);
    chk("post_reset_data", 32'(wlog[rst_idx].d), 32'hC0);

    // random interleaved bursts with random stalls
    rnd = 1;
    base = wlog.size();
    total = 0;
    while (total < 200) begin
      p = $urandom_range(0, N - 1);
      len = $urandom_range(1, 10);
      if (len > 200 - total) len = 200 - total;
      for (int k = 0; k < len; k++) begin
        logic [7:0] d;
        d = 8'($urandom);
        push_beat(p, d, k == len - 1);
        exp_s[p].push_back(d);
      end
      total += len;
    end
    run_until_idle("random", 5000);
    rnd = 0;
    chk("random_writes", wlog.size() - base, total);
    for (int q = 0; q < N; q++) begin
      j = 0;
      for (int k = base; k < wlog.size(); k++)
        if (wlog[k].src == q) begin
          if (j < exp_s[q].size()) chk("random_order", 32'(wlog[k].d), 32'(exp_s[q][j]));
          j++;
        end
      chk("random_count", j, exp_s[q].size());
    end
    cycle();
    chk("scoreboard_drained", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single 8-bit write port of the FWFT fifo among N_REQ producers using round-robin, burst-granular arbitration.
- A producer that wins keeps the port until its burst ends, so its bytes stay contiguous in the fifo.
- Sits directly upstream of the fifo and drives its write_enable and ui_in data inputs.
- Observes the fifo's full and almost_full flags so the fifo never sees an overflow.

Parameters:
- N_REQ, 4, number of producers; allowed range 2..8.
- MAX_BURST, 8, maximum beats per grant; allowed range 1..255.
- THROTTLE_ON_AFULL, 1, when 1 no new burst is started while fifo_almost_full is high.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-producer request; a producer holds its bit high while it has data to offer.
- req_data  in  8*N_REQ  per-producer data; producer i drives bits [8i+7:8i].
- req_last  in  N_REQ  marks the producer's current beat as the last beat of its burst.
- grant  out  N_REQ  per-producer beat-accepted strobe; combinational.
- fifo_full  in  1  fifo full flag.
- fifo_almost_full  in  1  fifo almost_full flag.
- fifo_wr_en  out  1  fifo write enable; combinational.
- fifo_wr_data  out  8  fifo write data; combinational mux of req_data by owner.
- busy  out  1  high while a burst is in progress (state BURST).
- owner  out  3  index of the current owner; valid only while busy.
- abort  out  1  one-cycle registered pulse when the owner drops req mid-burst.

Behaviour:
- State machine has two states:
  - IDLE: no producer owns the port.
  - BURST: one producer owns the port.
- Reset:
  - Takes priority over all other activity.
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, abort=0.
  - grant, fifo_wr_en and busy are 0 in the cycle after reset is sampled.
  - Reset asserted mid-burst drops the burst immediately; no write occurs in any cycle where reset is high.
- IDLE:
  - Let eligible = |req and !(THROTTLE_ON_AFULL and fifo_almost_full) and !fifo_full.
  - If eligible, winner = first set bit of req searching rr_ptr, rr_ptr+1, ..., wrapping mod N_REQ.
  - Next cycle: state=BURST, owner=winner, beat_cnt=0.
  - Arbitration latency is 1 cycle; no write ever occurs while in IDLE.
- BURST:
  - accept = req[owner] and !fifo_full.
  - fifo_wr_en = accept; grant[owner] = accept; all other grant bits are 0.
  - fifo_wr_data = req_data[owner]; value is don't-care when fifo_wr_en is 0.
  - On accept, beat_cnt increments; beat_cnt is 8 bits wide.
  - fifo_full stalls the burst: owner holds, beat_cnt holds, no grant, no fifo_wr_en.
  - fifo_almost_full has no effect during a burst.
- Burst end (evaluated every cycle in BURST; next state=IDLE, rr_ptr=(owner+1) mod N_REQ):
  - an accepted beat with req_last[owner]=1;
  - an accepted beat that makes beat_cnt+1 == MAX_BURST;
  - req[owner]=0: no write occurs and abort pulses high the next cycle.
- Fairness:
  - rr_ptr advances only at burst end, never on a stall.
  - A continuously requesting producer waits at most N_REQ-1 bursts.
- Simultaneous events:
  - Last beat while the fifo is full: the beat is not accepted and the burst continues until the beat is accepted.
  - The last-beat condition and the MAX_BURST condition together produce a single end event.
- IDLE to BURST always takes one cycle, so back-to-back bursts leave a 1-cycle bubble. This is required behaviour.
- The block never drives fifo_wr_en high while fifo_full is high.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - the OWNER_W constant, fixed at 3;
  - the BEAT_W constant, fixed at 8.
- Sub-module rr_picker: purely combinational.
  - Inputs: req, rr_ptr.
  - Outputs: winner index and a valid flag.
  - Implemented as a rotate, priority encode, then rotate back.

Test Plan:
- Contention: req=4'b1111, req_last always 1, fifo never full, bursts of 1 beat. Required: grants to producers 0,1,2,3,0 on consecutive bursts, each followed by a 1-cycle IDLE bubble.
- Burst cap: producer 2 alone requests 20 beats with req_last=0, MAX_BURST=8. Required: 8 writes, IDLE, 8 writes, IDLE, 4 writes; owner=2 throughout; abort pulses once when req drops.
- Full stall: fifo_full asserted for 3 cycles at beat 3 of a 5-beat burst from producer 1. Required: no fifo_wr_en and no grant during those 3 cycles; owner stays 1; burst completes with exactly 5 writes in order.
- Throttle: fifo_almost_full=1 with THROTTLE_ON_AFULL=1, req=4'b0100. Required: stays IDLE with busy=0. Deassert almost_full: busy=1 the next cycle.
- Abort and reset: producer 3 drops req after 2 beats. Required: abort=1 for exactly 1 cycle and the next winner is searched from rr_ptr=0. Reset during a later burst: busy=0 and grant=0 the next cycle, no write occurs in the reset cycle, and rr_ptr=0 afterwards.
- Data integrity: interleaved bursts with random stalls from 4 producers, 200 beats in total. Required: the fifo contents scoreboard matches per-producer order, bursts stay contiguous, and overflow never asserts.
